// File: rtl/mdu_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit: op encodings,
// default latencies and the unit's control states.
package mdu_pkg;

    localparam int MDU_OP_W          = 3;
    localparam int MDU_MULT_CYCLES   = 5;
    localparam int MDU_DIV_CYCLES    = 10;

    typedef enum logic [MDU_OP_W-1:0] {
        MDU_NONE  = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6
    } mdu_op_e;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_RUN  = 1'b1
    } mdu_state_e;

    function automatic logic is_mul_op(input logic [MDU_OP_W-1:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU);
    endfunction

    function automatic logic is_div_op(input logic [MDU_OP_W-1:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational datapath: 64-bit {hi,lo} product or {remainder,quotient}
// for the selected op, plus a divide-by-zero flag.
module mdu_calc
    import mdu_pkg::*;
(
    input  logic [MDU_OP_W-1:0] op_i,
    input  logic [31:0]         a_i,
    input  logic [31:0]         b_i,
    output logic [63:0]         result_o,
    output logic                div_by_zero_o
);

    logic signed [63:0] a_sx_s;
    logic signed [63:0] b_sx_s;
    logic signed [63:0] sprod_s;
    logic        [63:0] uprod_s;
    logic signed [31:0] a_s;
    logic signed [31:0] b_sdiv_s;
    logic signed [31:0] squot_s;
    logic signed [31:0] srem_s;
    logic        [31:0] b_udiv_s;
    logic        [31:0] uquot_s;
    logic        [31:0] urem_s;
    logic               b_zero_s;
    logic               s_ovf_s;

    assign b_zero_s = (b_i == 32'd0);
    // MIN_INT / -1 has no 32-bit quotient; dividing by 1 instead yields the
    // wrapped quotient 0x80000000 with remainder 0, with no undefined result.
    assign s_ovf_s  = (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);

    assign a_sx_s   = {{32{a_i[31]}}, a_i};
    assign b_sx_s   = {{32{b_i[31]}}, b_i};
    assign sprod_s  = a_sx_s * b_sx_s;
    assign uprod_s  = {32'd0, a_i} * {32'd0, b_i};

    assign a_s      = a_i;
    assign b_sdiv_s = (b_zero_s || s_ovf_s) ? 32'sd1 : b_i;
    assign squot_s  = a_s / b_sdiv_s;
    assign srem_s   = a_s % b_sdiv_s;

    assign b_udiv_s = b_zero_s ? 32'd1 : b_i;
    assign uquot_s  = a_i / b_udiv_s;
    assign urem_s   = a_i % b_udiv_s;

    assign div_by_zero_o = is_div_op(op_i) && b_zero_s;

    // Select the result for the requested op; non-arithmetic ops yield zero.
    always_comb begin
        result_o = 64'd0;
        case (op_i)
            MDU_MULT:  result_o = sprod_s;
            MDU_MULTU: result_o = uprod_s;
            MDU_DIV:   result_o = {srem_s, squot_s};
            MDU_DIVU:  result_o = {urem_s, uquot_s};
            default:   result_o = 64'd0;
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// Execute-stage MDU: holds HI/LO, a pending result and a latency counter;
// busy models the multi-cycle mult/div window seen by the hazard logic.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [MDU_OP_W-1:0] op,
    input  logic [31:0]         rs_val,
    input  logic [31:0]         rt_val,
    output logic                busy,
    output logic [31:0]         hi,
    output logic [31:0]         lo
);

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    mdu_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        ph_q, ph_d;
    logic [31:0]        pl_q, pl_d;
    logic               dz_q, dz_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;

    logic [63:0]        calc_result_s;
    logic               calc_dz_s;

    mdu_calc u_calc (
        .op_i          (op),
        .a_i           (rs_val),
        .b_i           (rt_val),
        .result_o      (calc_result_s),
        .div_by_zero_o (calc_dz_s)
    );

    // Next-state logic: accept ops in IDLE, count down and commit in RUN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ph_d    = ph_q;
        pl_d    = pl_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            MDU_IDLE: begin
                if (start) begin
                    case (op)
                        MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
                            ph_d    = calc_result_s[63:32];
                            pl_d    = calc_result_s[31:0];
                            dz_d    = calc_dz_s;
                            cnt_d   = is_mul_op(op) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                            state_d = MDU_RUN;
                        end
                        MDU_MTHI: hi_d = rs_val;
                        MDU_MTLO: lo_d = rs_val;
                        default:  state_d = MDU_IDLE;
                    endcase
                end else begin
                    state_d = MDU_IDLE;
                end
            end
            MDU_RUN: begin
                if (cnt_q == CNT_W'(1)) begin
                    // Divide by zero leaves HI/LO architecturally unchanged.
                    hi_d    = dz_q ? hi_q : ph_q;
                    lo_d    = dz_q ? lo_q : pl_q;
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = MDU_IDLE;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = MDU_IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, counter, pending result and HI/LO registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= MDU_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            ph_q    <= 32'd0;
            pl_q    <= 32'd0;
            dz_q    <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ph_q    <= ph_d;
            pl_q    <= pl_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q == MDU_RUN);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Execute-stage multiply/divide unit for the P6 pipelined `mips` core; consumes rs/rt operands forwarded into E and produces the HI/LO architectural registers.
- Models MIPS multi-cycle latency with a `busy` flag; the hazard controller uses it to stall mf/mt/md instructions in D.
- mfhi/mflo read `hi`/`lo` directly.

Parameters:
- MULT_CYCLES, 5, busy duration for mult/multu.
- DIV_CYCLES, 10, busy duration for div/divu.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; asserted when 0.
- start  in  1  E-stage instruction is an MDU op; qualifies op.
- op  in  3  operation code (package encoding).
- rs_val  in  32  operand A / mthi-mtlo source.
- rt_val  in  32  operand B.
- busy  out  1  multi-cycle operation in flight.
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
- Reset (reset=0, async): hi=0, lo=0, busy=0, internal counter=0, pending result=0. Reset mid-operation aborts it; no commit after release.
- Ops: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6. Codes 7 and NONE do nothing.
- Acceptance: op sampled at rising edge only when start=1 and busy=0. start while busy is ignored. The controller guarantees this never happens; the bench checks the state is untouched.
- MTHI/MTLO: hi (or lo) <= rs_val at the accepting edge; busy stays 0; latency 1 edge.
- MULT/MULTU: at accept edge T0, compute the 64-bit product (signed / unsigned) into pending {ph,pl}. Load counter=MULT_CYCLES; busy<=1.
- DIV/DIVU: quotient to pending lo, remainder to pending hi. Signed: quotient truncates toward zero; remainder takes the dividend's sign (-7/2 -> q=-3, r=-1). Load counter=DIV_CYCLES; busy<=1.
- Divide by zero: counter/busy behave normally; at commit hi/lo keep their previous values.
- Count: each edge while busy, counter decrements. At the edge where counter==1: hi<=ph, lo<=pl, busy<=0, counter<=0.
- busy is high for exactly N cycles (edges T1..TN). New hi/lo are visible after edge TN, together with busy falling.
- hi/lo hold their old values for the whole busy window.
- Back-to-back: a new start in the same cycle busy falls (busy still 1 before TN) is rejected. Accepted from edge TN+1 onward.
- State machine: IDLE (busy=0) -> RUN on accepted mult/div -> IDLE at counter==1. RUN ignores all inputs.
- Arithmetic: signed via $signed on 32-bit operands sign-extended to 64. No overflow traps.

Decomposition:
- Shared package `mdu_pkg`: op encodings (MDU_NONE..MDU_MTLO), op width 3, default cycle constants. The decoder/controller imports the same encodings.
- Sub-module `mdu_calc`: purely combinational; op, a, b -> 64-bit {hi,lo} result plus div_by_zero flag.
- Top `mult_div_unit` holds hi/lo, pending, counter and busy.

Test Plan:
- Reset: reset=0 mid-run with busy=1 -> busy=0, hi=lo=0 immediately (asynchronous); no later commit after release.
- MULT rs=0xFFFFFFFF (-1), rt=2 -> busy=1 for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- DIV rs=-7, rt=2 -> busy 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU rs=7, rt=2 -> lo=3, hi=1.
- Divide by zero: hi=0x11, lo=0x22 preset via MTHI/MTLO; DIV rt=0 -> busy 10 cycles, then hi=0x11, lo=0x22 unchanged.
- Start while busy: MULT then, during cycle 3, start with MTHI rs=0xABCD -> ignored; final hi/lo equal the first product only. A new MULT issued on the cycle after busy falls is accepted.
- MTHI rs=0x1234 -> hi=0x1234 after one edge with busy=0. MTLO similarly; op=7 with start=1 -> no change.
